// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : div_sequencer
// Description : Multi-cycle restoring divider for a pipeline EX stage.
//               Handles DIV, DIVU, REM and REMU, including divide-by-zero
//               and signed overflow. Raises a stall request while it works.
// Revision    : 1.0 - initial release
// ============================================================================
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam int              CW         = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   c_CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_cnt;
    logic             r_is_rem;     // latched op[1]: remainder wanted
    logic             r_neg_a;      // dividend negative (signed ops only)
    logic             r_neg_b;      // divisor negative (signed ops only)
    logic [WIDTH-1:0] r_quot;       // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] r_rem;        // partial remainder
    logic [WIDTH-1:0] r_div;        // divisor magnitude
    logic [WIDTH-1:0] r_result;

    logic             w_accept;
    logic             w_signed;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_div_zero;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic [WIDTH-1:0] w_fix_result;

    // Operand conditioning and one restoring step of the datapath
    always_comb begin
        w_accept     = (r_state == S_IDLE) && start && !flush;
        w_signed     = ~op[0];
        w_neg_a      = w_signed & operand_a[WIDTH-1];
        w_neg_b      = w_signed & operand_b[WIDTH-1];
        w_abs_a      = w_neg_a ? (~operand_a + 1'b1) : operand_a;
        w_abs_b      = w_neg_b ? (~operand_b + 1'b1) : operand_b;
        w_div_zero   = (operand_b == '0);
        w_shift      = {r_rem, r_quot[WIDTH-1]};
        w_trial      = w_shift - {1'b0, r_div};
        w_ge         = ~w_trial[WIDTH];
        // The most negative dividend over -1 falls out naturally: magnitude
        // quotient 2^(W-1) with equal signs is returned unchanged.
        w_q_fix      = (r_neg_a ^ r_neg_b) ? (~r_quot + 1'b1) : r_quot;
        w_r_fix      = r_neg_a ? (~r_rem + 1'b1) : r_rem;
        w_fix_result = r_is_rem ? w_r_fix : w_q_fix;
    end

    // Next-state selection; flush always wins over forward progress
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_div_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX: begin
                w_next_state = flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_rem <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_rem <= op[1];
                        r_neg_a  <= w_neg_a;
                        r_neg_b  <= w_neg_b;
                        r_quot   <= w_abs_a;
                        r_rem    <= '0;
                        r_div    <= w_abs_b;
                        if (w_div_zero) begin
                            r_result <= op[1] ? operand_a : '1;
                        end else begin
                            r_cnt <= c_CNT_INIT;
                        end
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        r_rem  <= w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
                        r_quot <= {r_quot[WIDTH-2:0], w_ge};
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_result <= w_fix_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Stall request and result handshake
    always_comb begin
        busy         = w_accept || (r_state == S_CALC) || (r_state == S_FIX);
        result_valid = (r_state == S_DONE) && !flush;
        result       = r_result;
    end

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_sequencer
// Description : Directed self-checking bench for div_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;

    int n_checks;
    int n_fail;

    localparam logic [1:0] c_DIV  = 2'b00;
    localparam logic [1:0] c_DIVU = 2'b01;
    localparam logic [1:0] c_REM  = 2'b10;
    localparam logic [1:0] c_REMU = 2'b11;

    div_sequencer #(.WIDTH(32)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .flush        (flush),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    // Start in cycle 0 (the cycle after the next falling edge), hold start
    // until result_valid, then check latency, result and busy profile.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_cyc, input bit chg);
        int          cyc;
        int          vcyc;
        int          bad;
        bit          got;
        logic        bdone;
        logic [31:0] res;
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        cyc = 0; vcyc = -1; bad = 0; got = 1'b0; bdone = 1'b1; res = 32'hDEAD_BEEF;
        while (!got && cyc <= exp_cyc + 5) begin
            #1;
            if (result_valid) begin
                got = 1'b1; vcyc = cyc; res = result; bdone = busy;
                start = 1'b0;
            end else begin
                if (busy !== 1'b1) bad++;
                @(posedge clk);
                @(negedge clk);
                cyc++;
                if (chg && cyc == 3) begin
                    operand_a = 32'h0001_2345;
                    op = ~o;
                end
            end
        end
        start = 1'b0;
        chk({tag, " latency"}, vcyc, exp_cyc);
        chk({tag, " result"}, res, exp);
        chk({tag, " busy_before"}, bad, 0);
        chk({tag, " busy_done"}, {31'd0, bdone}, 32'd0);
    endtask

    initial begin
        int seen;
        n_checks = 0; n_fail = 0;
        reset = 1'b1; start = 1'b0; op = 2'b00; flush = 1'b0;
        operand_a = '0; operand_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset valid", {31'd0, result_valid}, 32'd0);
        chk("reset result", result, 32'd0);

        run_op("divu 100/7",   c_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b0);
        // Held result after DONE, valid dropped
        @(negedge clk); #1;
        chk("hold result", result, 32'd14);
        chk("hold valid", {31'd0, result_valid}, 32'd0);

        run_op("remu 100/7",   c_REMU, 32'd100, 32'd7, 32'd2, 34, 1'b0);
        // Back-to-back starts follow directly from here
        run_op("div -7/2",     c_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0);
        run_op("rem -7/2",     c_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0);
        run_op("div 7/-2",     c_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b0);
        run_op("rem 7/-2",     c_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 1'b0);
        run_op("div -100/-7",  c_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 34, 1'b0);
        run_op("divu max/1",   c_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 1'b0);
        run_op("remu max/10",  c_REMU, 32'hFFFF_FFFF, 32'd10, 32'd5, 34, 1'b0);
        run_op("divu 5/0",     c_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
        run_op("rem 5/0",      c_REM, 32'd5, 32'd0, 32'd5, 1, 1'b0);
        run_op("div ovf",      c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b0);
        run_op("rem ovf",      c_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 1'b0);
        run_op("div opchg",    c_DIV, 32'd1000, 32'd3, 32'd333, 34, 1'b1);

        // Flush during CALC: start in cycle 0, flush in cycle 10
        @(negedge clk);
        start = 1'b1; op = c_DIVU; operand_a = 32'd200; operand_b = 32'd9;
        seen = 0;
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) begin flush = 1'b1; start = 1'b0; end
            #1;
            if (result_valid) seen++;
            @(posedge clk);
            @(negedge clk);
        end
        flush = 1'b0;
        #1;
        if (result_valid) seen++;
        chk("flush busy", {31'd0, busy}, 32'd0);
        chk("flush no_valid", seen, 0);
        run_op("after flush",  c_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b0);

        // Reset during CALC: start in cycle 0, reset in cycle 5
        @(negedge clk);
        start = 1'b1; op = c_DIVU; operand_a = 32'd77; operand_b = 32'd5;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (result_valid) seen++;
            if (c == 4) chk("pre-reset hold", result, 32'd14);
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        #1;
        if (result_valid) seen++;
        chk("midreset result", result, 32'd0);
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset no_valid", seen, 0);
        run_op("after reset",  c_REMU, 32'd77, 32'd5, 32'd2, 34, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
